// File: rtl/ahb_bridge_arbiter.sv
// Round-robin arbiter sharing one bridge packet port between two requesters; grant and br_valid register 1 cycle after valid.
// Grant is held through br_ready stalls and the read return; a read that never returns is force-completed after TIMEOUT cycles.
module ahb_bridge_arbiter #(
    parameter int PKT_W   = 41,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              HCLK,
    input  logic              RESETn,
    input  logic [PKT_W-1:0]  req0_packet,
    input  logic              req0_valid,
    output logic              req0_ready,
    output logic [DATA_W-1:0] req0_rd_data,
    output logic              req0_rd_valid,
    input  logic [PKT_W-1:0]  req1_packet,
    input  logic              req1_valid,
    output logic              req1_ready,
    output logic [DATA_W-1:0] req1_rd_data,
    output logic              req1_rd_valid,
    output logic [PKT_W-1:0]  br_packet,
    output logic              br_valid,
    input  logic              br_ready,
    input  logic [DATA_W-1:0] br_rd_data,
    input  logic              br_rd_valid,
    output logic [1:0]        grant,
    output logic              timeout_err
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_WAIT_RD = 2'd2;

    localparam int          TW   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

    logic [1:0]        state_q, state_d;
    logic [1:0]        grant_q, grant_d;
    logic              last_q, last_d;
    logic [PKT_W-1:0]  pkt_q, pkt_d;
    logic              bv_q, bv_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [DATA_W-1:0] rd0_q, rd0_d, rd1_q, rd1_d;
    logic              rv0_q, rv0_d, rv1_q, rv1_d;
    logic              terr_q, terr_d;
    logic              win1;
    logic [DATA_W-1:0] ret_data;

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        last_d   = last_q;
        pkt_d    = pkt_q;
        bv_d     = bv_q;
        timer_d  = timer_q;
        rd0_d    = rd0_q;
        rd1_d    = rd1_q;
        rv0_d    = 1'b0;
        rv1_d    = 1'b0;
        terr_d   = 1'b0;
        win1     = 1'b0;
        ret_data = '0;
        case (state_q)
            ST_IDLE: begin
                if (req0_valid || req1_valid) begin
                    // last_q holds the index of the previous owner; the other side wins a tie
                    win1    = req1_valid && (!req0_valid || !last_q);
                    pkt_d   = win1 ? req1_packet : req0_packet;
                    grant_d = win1 ? 2'b10 : 2'b01;
                    bv_d    = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (br_ready) begin
                    bv_d = 1'b0;
                    if (pkt_q[PKT_W-1]) begin
                        state_d = ST_IDLE;
                        grant_d = 2'b00;
                        last_d  = grant_q[1];
                    end else begin
                        state_d = ST_WAIT_RD;
                        timer_d = '0;
                    end
                end
            end
            ST_WAIT_RD: begin
                timer_d = timer_q + 1'b1;
                if (br_rd_valid || (timer_q == TMAX)) begin
                    // real data beats a coincident timeout
                    ret_data = br_rd_valid ? br_rd_data : '0;
                    terr_d   = !br_rd_valid;
                    if (grant_q[1]) begin
                        rd1_d = ret_data;
                        rv1_d = 1'b1;
                    end else begin
                        rd0_d = ret_data;
                        rv0_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                    grant_d = 2'b00;
                    last_d  = grant_q[1];
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = 2'b00;
                bv_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge HCLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q <= ST_IDLE;
            grant_q <= 2'b00;
            last_q  <= 1'b1;
            pkt_q   <= '0;
            bv_q    <= 1'b0;
            timer_q <= '0;
            rd0_q   <= '0;
            rd1_q   <= '0;
            rv0_q   <= 1'b0;
            rv1_q   <= 1'b0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            pkt_q   <= pkt_d;
            bv_q    <= bv_d;
            timer_q <= timer_d;
            rd0_q   <= rd0_d;
            rd1_q   <= rd1_d;
            rv0_q   <= rv0_d;
            rv1_q   <= rv1_d;
            terr_q  <= terr_d;
        end
    end

    assign req0_ready    = (state_q == ST_ISSUE) && grant_q[0] && br_ready;
    assign req1_ready    = (state_q == ST_ISSUE) && grant_q[1] && br_ready;
    assign req0_rd_data  = rd0_q;
    assign req1_rd_data  = rd1_q;
    assign req0_rd_valid = rv0_q;
    assign req1_rd_valid = rv1_q;
    assign br_packet     = pkt_q;
    assign br_valid      = bv_q;
    assign grant         = grant_q;
    assign timeout_err   = terr_q;

endmodule

// File: tb/tb_ahb_bridge_arbiter.sv
// Directed-vector bench for ahb_bridge_arbiter; inputs change and outputs are sampled on the falling edge.
module tb_ahb_bridge_arbiter;

    logic        HCLK = 1'b0;
    logic        RESETn = 1'b0;
    logic [40:0] req0_packet = '0, req1_packet = '0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_rd_data, req1_rd_data;
    logic        req0_rd_valid, req1_rd_valid;
    logic [40:0] br_packet;
    logic        br_valid;
    logic        br_ready = 1'b0;
    logic [31:0] br_rd_data = '0;
    logic        br_rd_valid = 1'b0;
    logic [1:0]  grant;
    logic        timeout_err;

    int vecs = 0;
    int errs = 0;
    int leak = 0;

    ahb_bridge_arbiter #(.PKT_W(41), .DATA_W(32), .TIMEOUT(16)) dut (
        .HCLK(HCLK), .RESETn(RESETn),
        .req0_packet(req0_packet), .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_rd_data(req0_rd_data), .req0_rd_valid(req0_rd_valid),
        .req1_packet(req1_packet), .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_rd_data(req1_rd_data), .req1_rd_valid(req1_rd_valid),
        .br_packet(br_packet), .br_valid(br_valid), .br_ready(br_ready),
        .br_rd_data(br_rd_data), .br_rd_valid(br_rd_valid),
        .grant(grant), .timeout_err(timeout_err)
    );

    always #5 HCLK = ~HCLK;

    always @(negedge HCLK)
        if ((req0_ready && !grant[0]) || (req1_ready && !grant[1])) leak++;

    task automatic tick();
        @(negedge HCLK);
    endtask

    task automatic test_reset();
        RESETn = 1'b0;
        tick();
        tick();
        vecs++;
        if ({br_valid, grant, req0_rd_valid, req1_rd_valid, timeout_err} !== 6'b0) begin
            errs++;
            $display("FAIL reset_ctl: got %b want 000000", {br_valid, grant, req0_rd_valid, req1_rd_valid, timeout_err});
        end
        vecs++;
        if ({br_packet, req0_rd_data, req1_rd_data} !== 105'b0) begin
            errs++;
            $display("FAIL reset_data: got %h/%h/%h want 0", br_packet, req0_rd_data, req1_rd_data);
        end
        RESETn = 1'b1;
        tick();
    endtask

    task automatic test_write();
        logic [40:0] pkt;
        pkt = {1'b1, 32'hA5A5_0001, 8'h10};
        req0_packet = pkt;
        req0_valid  = 1'b1;
        tick();
        req0_valid = 1'b0;
        vecs++;
        if ({br_valid, grant, br_packet} !== {1'b1, 2'b01, 41'h1_A5A5_0001_10}) begin
            errs++;
            $display("FAIL wr_issue: got v=%b g=%b p=%h want v=1 g=01 p=1a5a5000110", br_valid, grant, br_packet);
        end
        vecs++;
        if (req0_ready !== 1'b0) begin
            errs++;
            $display("FAIL wr_ready_early: got %b want 0", req0_ready);
        end
        tick();
        tick();
        br_ready = 1'b1;
        #1;
        vecs++;
        if ({req0_ready, req1_ready, br_valid} !== 3'b101) begin
            errs++;
            $display("FAIL wr_accept: got r0=%b r1=%b v=%b want 1 0 1", req0_ready, req1_ready, br_valid);
        end
        tick();
        br_ready = 1'b0;
        vecs++;
        if ({br_valid, grant, req0_ready} !== 4'b0) begin
            errs++;
            $display("FAIL wr_done: got v=%b g=%b r0=%b want 0 00 0", br_valid, grant, req0_ready);
        end
    endtask

    task automatic test_read();
        req1_packet = {1'b0, 32'h0, 8'h24};
        req1_valid  = 1'b1;
        tick();
        req1_valid = 1'b0;
        br_ready   = 1'b1;
        #1;
        vecs++;
        if ({grant, br_valid, req1_ready, req0_ready} !== 5'b10110) begin
            errs++;
            $display("FAIL rd_issue: got g=%b v=%b r1=%b r0=%b want 10 1 1 0", grant, br_valid, req1_ready, req0_ready);
        end
        tick();
        br_ready = 1'b0;
        tick();
        tick();
        br_rd_valid = 1'b1;
        br_rd_data  = 32'hDEAD_BEEF;
        vecs++;
        if ({grant, req1_rd_valid} !== 3'b100) begin
            errs++;
            $display("FAIL rd_wait: got g=%b rv1=%b want 10 0", grant, req1_rd_valid);
        end
        tick();
        br_rd_valid = 1'b0;
        br_rd_data  = 32'h0;
        vecs++;
        if ({req1_rd_valid, req0_rd_valid, req1_rd_data, grant, timeout_err} !== {2'b10, 32'hDEAD_BEEF, 3'b000}) begin
            errs++;
            $display("FAIL rd_return: got rv1=%b rv0=%b d=%h g=%b te=%b want 1 0 deadbeef 00 0",
                     req1_rd_valid, req0_rd_valid, req1_rd_data, grant, timeout_err);
        end
        tick();
        vecs++;
        if ({req1_rd_valid, req1_rd_data} !== {1'b0, 32'hDEAD_BEEF}) begin
            errs++;
            $display("FAIL rd_pulse_hold: got rv1=%b d=%h want 0 deadbeef", req1_rd_valid, req1_rd_data);
        end
    endtask

    task automatic test_alternate();
        logic [1:0] exp_g [4];
        exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
        RESETn = 1'b0;
        tick();
        RESETn = 1'b1;
        req0_packet = {1'b1, 32'h1111_1111, 8'h01};
        req1_packet = {1'b1, 32'h2222_2222, 8'h02};
        req0_valid  = 1'b1;
        req1_valid  = 1'b1;
        br_ready    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            vecs++;
            if (grant !== exp_g[i] || br_packet !== (exp_g[i][0] ? req0_packet : req1_packet)) begin
                errs++;
                $display("FAIL alt_grant%0d: got g=%b p=%h want g=%b", i, grant, br_packet, exp_g[i]);
            end
            tick();
            vecs++;
            if ({grant, br_valid} !== 3'b000) begin
                errs++;
                $display("FAIL alt_idle%0d: got g=%b v=%b want 00 0", i, grant, br_valid);
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        br_ready   = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        req0_packet = {1'b1, 32'h3333_3333, 8'h03};
        req0_valid  = 1'b1;
        br_ready    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            vecs++;
            if ({grant, req0_ready} !== 3'b011) begin
                errs++;
                $display("FAIL b2b_grant%0d: got g=%b r0=%b want 01 1", i, grant, req0_ready);
            end
            tick();
        end
        req0_valid = 1'b0;
        br_ready   = 1'b0;
        tick();
    endtask

    task automatic start_read0();
        req0_packet = {1'b0, 32'h0, 8'h30};
        req0_valid  = 1'b1;
        tick();
        req0_valid = 1'b0;
        br_ready   = 1'b1;
        tick();
        br_ready = 1'b0;
    endtask

    task automatic test_timeout_race();
        start_read0();
        for (int k = 0; k < 15; k++) tick();
        br_rd_valid = 1'b1;
        br_rd_data  = 32'h1234_5678;
        tick();
        br_rd_valid = 1'b0;
        br_rd_data  = 32'h0;
        vecs++;
        if ({req0_rd_valid, req0_rd_data, timeout_err} !== {1'b1, 32'h1234_5678, 1'b0}) begin
            errs++;
            $display("FAIL to_race: got rv0=%b d=%h te=%b want 1 12345678 0", req0_rd_valid, req0_rd_data, timeout_err);
        end
        tick();
    endtask

    task automatic test_timeout();
        int early;
        early = 0;
        start_read0();
        for (int k = 0; k < 15; k++) begin
            if (req0_rd_valid || timeout_err) early++;
            tick();
        end
        if (req0_rd_valid || timeout_err) early++;
        vecs++;
        if (early !== 0) begin
            errs++;
            $display("FAIL to_early: got %0d early completions want 0", early);
        end
        tick();
        vecs++;
        if ({req0_rd_valid, req0_rd_data, timeout_err, grant} !== {1'b1, 32'h0, 1'b1, 2'b00}) begin
            errs++;
            $display("FAIL to_fire: got rv0=%b d=%h te=%b g=%b want 1 0 1 00", req0_rd_valid, req0_rd_data, timeout_err, grant);
        end
        tick();
        vecs++;
        if ({req0_rd_valid, timeout_err} !== 2'b00) begin
            errs++;
            $display("FAIL to_pulse: got rv0=%b te=%b want 0 0", req0_rd_valid, timeout_err);
        end
    endtask

    task automatic test_reset_mid();
        req1_packet = {1'b0, 32'h0, 8'h44};
        req1_valid  = 1'b1;
        tick();
        req1_valid = 1'b0;
        br_ready   = 1'b1;
        tick();
        br_ready = 1'b0;
        tick();
        #2;
        RESETn = 1'b0;
        #1;
        vecs++;
        if ({grant, br_valid, req0_rd_valid, req1_rd_valid, timeout_err, req1_rd_data} !== 38'b0) begin
            errs++;
            $display("FAIL rst_async: got g=%b v=%b d1=%h want all 0", grant, br_valid, req1_rd_data);
        end
        tick();
        RESETn      = 1'b1;
        br_rd_valid = 1'b1;
        br_rd_data  = 32'hFEED_0001;
        tick();
        br_rd_valid = 1'b0;
        tick();
        vecs++;
        if ({req1_rd_valid, req0_rd_valid, req1_rd_data, grant} !== 36'b0) begin
            errs++;
            $display("FAIL rst_ignore: got rv1=%b rv0=%b d1=%h g=%b want 0", req1_rd_valid, req0_rd_valid, req1_rd_data, grant);
        end
    endtask

    task automatic test_stall();
        logic [40:0] pkt0, pkt1;
        int bad;
        bad  = 0;
        pkt0 = {1'b1, 32'hCAFE_F00D, 8'h55};
        pkt1 = {1'b1, 32'h0BAD_CAFE, 8'h66};
        req0_packet = pkt0;
        req0_valid  = 1'b1;
        tick();
        req0_valid  = 1'b0;
        req0_packet = '0;
        req1_packet = pkt1;
        req1_valid  = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (br_valid !== 1'b1 || br_packet !== pkt0 || grant !== 2'b01 || req1_ready) bad++;
            tick();
        end
        vecs++;
        if (bad !== 0) begin
            errs++;
            $display("FAIL stall_hold: got %0d unstable cycles want 0", bad);
        end
        br_ready = 1'b1;
        #1;
        vecs++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errs++;
            $display("FAIL stall_accept: got r0=%b r1=%b want 1 0", req0_ready, req1_ready);
        end
        tick();
        br_ready = 1'b0;
        vecs++;
        if ({grant, br_valid} !== 3'b000) begin
            errs++;
            $display("FAIL stall_gap: got g=%b v=%b want 00 0", grant, br_valid);
        end
        tick();
        req1_valid = 1'b0;
        vecs++;
        if ({grant, br_valid, br_packet} !== {2'b10, 1'b1, pkt1}) begin
            errs++;
            $display("FAIL stall_pending: got g=%b v=%b p=%h want 10 1 %h", grant, br_valid, br_packet, pkt1);
        end
        br_ready = 1'b1;
        tick();
        br_ready = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_alternate();
        test_back_to_back();
        test_timeout_race();
        test_timeout();
        test_reset_mid();
        test_stall();
        vecs++;
        if (leak !== 0) begin
            errs++;
            $display("FAIL ready_leak: got %0d cycles of ready to non-owner want 0", leak);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
